// File: rtl/instr_sequencer_pkg.sv
// instr_pkg: shared types and constants for the instruction sequencer.
// Holds the FSM state type, opcode and ALU-control encodings, instruction
// field positions and the packed control payload driven to the datapath.
package instr_pkg;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned REG_W   = 4;
   localparam int unsigned IMM_W   = 8;
   localparam int unsigned ALU_W   = 2;

   // Instruction field positions
   localparam int unsigned OP_MSB  = 15;
   localparam int unsigned OP_LSB  = 12;
   localparam int unsigned D_MSB   = 11;
   localparam int unsigned D_LSB   = 8;
   localparam int unsigned S_MSB   = 7;
   localparam int unsigned S_LSB   = 4;
   localparam int unsigned T_MSB   = 3;
   localparam int unsigned T_LSB   = 0;
   localparam int unsigned IMM_MSB = 7;
   localparam int unsigned IMM_LSB = 0;

   typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_AND  = 4'h1;
   localparam logic [3:0] OP_OR   = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_ANDI = 4'h5;
   localparam logic [3:0] OP_ORI  = 4'h6;
   localparam logic [3:0] OP_ADDI = 4'h7;
   localparam logic [3:0] OP_SUBI = 4'h8;
   localparam logic [3:0] OP_BZ   = 4'h9;
   localparam logic [3:0] OP_JMP  = 4'hB;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [ALU_W-1:0] ALU_AND = 2'b00;
   localparam logic [ALU_W-1:0] ALU_OR  = 2'b01;
   localparam logic [ALU_W-1:0] ALU_ADD = 2'b10;
   localparam logic [ALU_W-1:0] ALU_SUB = 2'b11;

   // Datapath control payload decoded from one instruction
   typedef struct packed {
      logic [REG_W-1:0] ra1;
      logic [REG_W-1:0] ra2;
      logic [REG_W-1:0] wa;
      logic             we;
      logic             alu_src;
      logic [ALU_W-1:0] alu_ctrl;
      logic [IMM_W-1:0] imm;
   } ctrl_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: ROM fetch bus plus datapath control/flag signals.
//   master (sequencer): drives instr_addr, RA1, RA2, WA, write_enable,
//                       ALUSrc, ALUControl, immediate; reads instr_data, Zero.
//   slave  (ROM + datapath): the reverse directions.
interface instr_sequencer_if
   import instr_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
) ();

   logic [ADDR_W-1:0]  instr_addr;
   logic [INSTR_W-1:0] instr_data;
   logic               Zero;
   logic [REG_W-1:0]   RA1;
   logic [REG_W-1:0]   RA2;
   logic [REG_W-1:0]   WA;
   logic               write_enable;
   logic               ALUSrc;
   logic [ALU_W-1:0]   ALUControl;
   logic [IMM_W-1:0]   immediate;

   modport master (
      output instr_addr, RA1, RA2, WA, write_enable, ALUSrc, ALUControl, immediate,
      input  instr_data, Zero
   );

   modport slave (
      input  instr_addr, RA1, RA2, WA, write_enable, ALUSrc, ALUControl, immediate,
      output instr_data, Zero
   );

endinterface

// File: rtl/instr_sequencer_decode.sv
// instr_decode: purely combinational instruction decoder.
//   ir         in   instruction register
//   ctrl       out  datapath control payload for this instruction
//   is_branch  out  BZ
//   is_jump    out  JMP
//   is_halt    out  HALT
//   is_illegal out  undefined opcode (treated as NOP)
module instr_decode
   import instr_pkg::*;
(
   input  logic [INSTR_W-1:0] ir,
   output ctrl_t              ctrl,
   output logic               is_branch,
   output logic               is_jump,
   output logic               is_halt,
   output logic               is_illegal
);

   logic [3:0]       op;
   logic [REG_W-1:0] fd;
   logic [REG_W-1:0] fs;
   logic [REG_W-1:0] ft;
   logic [IMM_W-1:0] fimm;

   assign op   = ir[OP_MSB:OP_LSB];
   assign fd   = ir[D_MSB:D_LSB];
   assign fs   = ir[S_MSB:S_LSB];
   assign ft   = ir[T_MSB:T_LSB];
   assign fimm = ir[IMM_MSB:IMM_LSB];

   // Opcode to control mapping; the ALU code is the offset within each op group
   always_comb begin
      ctrl       = '0;
      is_branch  = 1'b0;
      is_jump    = 1'b0;
      is_halt    = 1'b0;
      is_illegal = 1'b0;
      case (op)
         OP_NOP: ;
         OP_AND, OP_OR, OP_ADD, OP_SUB: begin
            ctrl.wa       = fd;
            ctrl.ra1      = fs;
            ctrl.ra2      = ft;
            ctrl.alu_ctrl = ALU_W'(op - OP_AND);
            ctrl.we       = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_ADDI, OP_SUBI: begin
            ctrl.wa       = fd;
            ctrl.ra1      = fd;
            ctrl.alu_src  = 1'b1;
            ctrl.imm      = fimm;
            ctrl.alu_ctrl = ALU_W'(op - OP_ANDI);
            ctrl.we       = 1'b1;
         end
         OP_BZ: begin
            // rd OR 0 lets the datapath produce Zero for rd
            ctrl.ra1      = fd;
            ctrl.alu_src  = 1'b1;
            ctrl.alu_ctrl = ALU_OR;
            is_branch     = 1'b1;
         end
         OP_JMP:  is_jump    = 1'b1;
         OP_HALT: is_halt    = 1'b1;
         default: is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: two-cycle FETCH/EXEC controller for the register-file/ALU datapath.
//   CLK, RST_N  clock (rising edge) and asynchronous active-low reset
//   start       leaves IDLE and begins fetching at PC 0
//   bus         master side: ROM address/data and datapath control/Zero flag
//   pc          current instruction address
//   halted      high in the HALT state
//   illegal     sticky undefined-opcode flag, cleared only by reset
module instr_sequencer
   import instr_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     start,
   instr_sequencer_if.master        bus,
   output logic [ADDR_W-1:0]        pc,
   output logic                     halted,
   output logic                     illegal
);

   state_t             state;
   logic [INSTR_W-1:0] ir;
   ctrl_t              ctrl;
   logic               is_branch;
   logic               is_jump;
   logic               is_halt;
   logic               is_illegal;
   logic               exec_c;
   logic [ADDR_W-1:0]  pc_next_c;

   instr_decode u_decode (
      .ir         (ir),
      .ctrl       (ctrl),
      .is_branch  (is_branch),
      .is_jump    (is_jump),
      .is_halt    (is_halt),
      .is_illegal (is_illegal)
   );

   // Next PC, all arithmetic modulo 2^ADDR_W; branch offset is relative to the BZ address
   always_comb begin
      pc_next_c = pc + ADDR_W'(1);
      if (is_halt) begin
         pc_next_c = pc;
      end else if (is_jump) begin
         pc_next_c = ADDR_W'(ir[IMM_MSB:IMM_LSB]);
      end else if (is_branch && bus.Zero) begin
         pc_next_c = pc + ADDR_W'($signed(ir[IMM_MSB:IMM_LSB]));
      end
   end

   // FSM, PC, IR and status flags
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= IDLE;
         pc      <= '0;
         ir      <= '0;
         halted  <= 1'b0;
         illegal <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) state <= FETCH;
            end
            FETCH: begin
               ir    <= bus.instr_data;
               state <= EXEC;
            end
            EXEC: begin
               pc <= pc_next_c;
               if (is_illegal) illegal <= 1'b1;
               if (is_halt) begin
                  state  <= HALT;
                  halted <= 1'b1;
               end else begin
                  state <= FETCH;
               end
            end
            HALT:    state <= HALT;
            default: state <= IDLE;
         endcase
      end
   end

   // Datapath controls are live only in EXEC so they drop with the state on reset
   assign exec_c           = (state == EXEC);
   assign bus.instr_addr   = pc;
   assign bus.RA1          = exec_c ? ctrl.ra1      : '0;
   assign bus.RA2          = exec_c ? ctrl.ra2      : '0;
   assign bus.WA           = exec_c ? ctrl.wa       : '0;
   assign bus.write_enable = exec_c & ctrl.we;
   assign bus.ALUSrc       = exec_c & ctrl.alu_src;
   assign bus.ALUControl   = exec_c ? ctrl.alu_ctrl : '0;
   assign bus.immediate    = exec_c ? ctrl.imm      : '0;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/decode/execute controller directly upstream of the register-file/ALU datapath.
- Reads 16-bit instructions from a synchronous instruction ROM and drives the datapath control inputs: RA1, RA2, WA, write_enable, ALUSrc, ALUControl and immediate.
- Consumes the datapath Zero flag for conditional branches.
- Runs two cycles per instruction (FETCH, EXEC) until a HALT instruction.

Parameters:
- ADDR_W, 8, program counter and ROM address width; the PC wraps modulo 2^ADDR_W.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- start  in  1  leaves IDLE and begins fetching at PC 0.
- instr_addr  out  ADDR_W  ROM address; equals pc.
- instr_data  in  16  ROM data, valid the cycle after instr_addr is presented.
- Zero  in  1  ALU zero flag from the datapath.
- RA1, RA2, WA  out  4 each  register addresses.
- write_enable  out  1  register-file write strobe.
- ALUSrc  out  1  1 selects immediate as SrcB.
- ALUControl  out  2  00 AND, 01 OR, 10 ADD, 11 SUB.
- immediate  out  8  immediate operand.
- pc  out  ADDR_W  current instruction address.
- halted  out  1  high in the HALT state.
- illegal  out  1  sticky flag, set on an undefined opcode.

Behaviour:
- Clock and reset: one clock (CLK); reset is asynchronous and active-low (RST_N).
- Reset values: state=IDLE, pc=0, IR=0, halted=0, illegal=0; all datapath outputs 0.
- Instruction format: op=[15:12], d=[11:8], s=[7:4], t=[3:0], imm=[7:0].
- FSM states: IDLE, FETCH, EXEC, HALT.
  - IDLE: hold; start=1 -> FETCH.
  - FETCH: instr_addr=pc; at the clock edge IR<=instr_data -> EXEC.
  - EXEC: outputs decoded combinationally from IR; pc updated at the clock edge; -> FETCH, or -> HALT for op F.
  - HALT: halted=1; stay until reset. start is ignored.
- Datapath outputs are 0 in every state except EXEC, including write_enable=0.
- Register ops (op 1-4 = AND, OR, ADD, SUB):
  - WA=d, RA1=s, RA2=t, ALUSrc=0.
  - ALUControl = op-1.
  - write_enable=1 for exactly the EXEC cycle.
- Immediate ops (op 5-8 = ANDI, ORI, ADDI, SUBI):
  - WA=d, RA1=d, ALUSrc=1, immediate=imm.
  - ALUControl = op-5.
  - write_enable=1.
- BZ (op 9):
  - RA1=d, ALUSrc=1, immediate=0, ALUControl=01 (OR), write_enable=0.
  - Zero is sampled at the end of EXEC.
  - Zero=1: pc <= pc + sign-extended imm (relative to the BZ address).
  - Zero=0: pc <= pc+1.
- JMP (op B): pc <= imm, zero-extended or truncated to ADDR_W; write_enable=0.
- NOP (op 0): pc+1, no write.
- HALT (op F): no write; pc is not incremented.
- Undefined opcodes (A, C, D, E): executed as NOP; illegal set, cleared only by reset.
- PC arithmetic:
  - All PC arithmetic is modulo 2^ADDR_W.
  - pc=255 with a non-branch op -> pc=0 (ADDR_W=8).
  - A negative offset below 0 wraps.
- Register 0: writes with d=0 are issued normally; the datapath discards them.
- Reset mid-operation: RST_N low in any state immediately forces the reset values; write_enable drops combinationally with the state.
- start held high: it is only sampled in IDLE.
- ROM latency is fixed at 1 cycle; there is no stall handshake.

Decomposition:
- Package instr_pkg holds:
  - typedef enum state_t {IDLE, FETCH, EXEC, HALT};
  - opcode constants OP_NOP..OP_HALT;
  - ALU control constants ALU_AND/OR/ADD/SUB;
  - field-position localparams.
- Sub-module instr_decode (purely combinational: IR -> control outputs, is_branch, is_jump, is_halt, is_illegal).
- The top level holds the FSM, pc and IR.

Test Plan:
- Reset then start with ROM[0]=0x7305 (ADDI r3,5).
  - EXEC at cycle 2: WA=3, RA1=3, ALUSrc=1, immediate=5, ALUControl=10, write_enable=1 for one cycle.
  - pc=1 afterwards.
- ROM[1]=0x3F12 (ADD r15,r1,r2) -> WA=15, RA1=1, RA2=2, ALUSrc=0, ALUControl=10, write_enable=1.
- BZ 0x9203 at pc=4.
  - Zero=1 -> next pc=7.
  - Zero=0 -> next pc=5.
  - 0x92FE at pc=4 with Zero=1 -> pc=2.
- JMP 0xB0FF -> pc=255; NOP at 255 -> pc=0 (wrap).
- HALT 0xF000 -> halted=1, pc unchanged, write_enable stays 0 for 10 cycles despite start pulses.
- Opcode 0xA123 -> illegal=1, no write, pc+1; RST_N pulsed low mid-EXEC -> all outputs 0 asynchronously, state IDLE, illegal=0.
